register_1bit_en: RTL and testbench

- Single-bit storage element with synchronous active-high reset and a write enable.
- Datapath building block for holding flags and control bits; widenable via parameter.
- Output is registered; no combinational path from inputs to output.

---
 rtl/register_1bit_en.sv | 24 ++
 tb/tb_register_1bit_en.sv | 133 +++++++++++++
 2 files changed

// File: rtl/register_1bit_en.sv
// Storage register with load enable and synchronous reset; default is a single flag bit.
// Latency: one cycle from a capturing rising edge of clk to data_out.
// Backpressure: none; write_en is a plain load strobe and the register never stalls.
module register_1bit_en #(
    parameter int unsigned     WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    // Reset outranks the load so a write on the reset edge is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= RESET_VALUE;
        end else if (write_en) begin
            data_out <= data_in;
        end
    end

endmodule

// File: tb/tb_register_1bit_en.sv
// Directed and random checks of register_1bit_en at WIDTH 1, 4 and 8 (non-zero reset value).
module tb_register_1bit_en;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [7:0] din;
    logic       q1;
    logic [3:0] q4;
    logic [7:0] q8;

    logic       m1;
    logic [3:0] m4;
    logic [7:0] m8;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] RV8 = 8'h5A;

    always #5 clk = ~clk;

    register_1bit_en u_w1 (
        .clk(clk), .rst(rst), .write_en(we), .data_in(din[0]), .data_out(q1)
    );

    register_1bit_en #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .write_en(we), .data_in(din[3:0]), .data_out(q4)
    );

    register_1bit_en #(.WIDTH(8), .RESET_VALUE(RV8)) u_w8 (
        .clk(clk), .rst(rst), .write_en(we), .data_in(din), .data_out(q8)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_w1"}, {7'd0, q1}, {7'd0, m1});
        check({tag, "_w4"}, {4'd0, q4}, {4'd0, m4});
        check({tag, "_w8"}, q8, m8);
    endtask

    // Reference: reset loads the reset value, else a write loads data, else hold.
    task automatic edge_step(input string tag);
        @(posedge clk);
        if (rst) begin
            m1 = 1'b0;
            m4 = 4'h0;
            m8 = RV8;
        end else if (we) begin
            m1 = din[0];
            m4 = din[3:0];
            m8 = din;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    // Disturb inputs between edges; outputs must not move until the next rising edge.
    task automatic mid_cycle(input string tag, input logic new_rst, input logic new_we,
                             input logic [7:0] new_din);
        #2;
        rst = new_rst;
        we  = new_we;
        din = new_din;
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        din = 8'hFF;
        m1  = 1'bx;
        m4  = 'x;
        m8  = 'x;

        edge_step("reset_dominates");

        rst = 1'b0; we = 1'b1; din = 8'hFB;
        edge_step("write_one");

        din = 8'h2A;
        edge_step("write_zero_w4_a");

        we = 1'b0; din = 8'hFF;
        edge_step("hold_we_low");

        we = 1'b1; din = 8'hFF;
        edge_step("write_ones");

        rst = 1'b1; we = 1'b1; din = 8'hFF;
        edge_step("reset_beats_write");

        rst = 1'b0; we = 1'b1; din = 8'hA5;
        edge_step("write_a5");

        mid_cycle("mid_rst_raise", 1'b1, 1'b0, 8'h00);
        edge_step("rst_after_mid");

        rst = 1'b0; we = 1'b1; din = 8'hC3;
        edge_step("write_c3");
        mid_cycle("mid_din_toggle", 1'b0, 1'b1, 8'h3C);
        edge_step("write_3c");

        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = ~din;
            edge_step("hold_din_toggling");
        end

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 9) == 0);
            we  = $urandom_range(0, 1) == 1;
            din = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                mid_cycle("rand_mid", $urandom_range(0, 7) == 0,
                          $urandom_range(0, 1) == 1, 8'($urandom));
            end
            edge_step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
